// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the program-counter fetch unit.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_TRAP   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_e;

  localparam int unsigned ILEN_BYTES = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target mux with instruction-alignment check.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] jalr_sum;
  pc_src_e         src;

  assign src      = pc_src_e'(pc_src);
  assign jalr_sum = rs1_val + imm;

  always_comb begin
    target = pc + XLEN'(ILEN_BYTES);
    unique case (src)
      PC_SEQ:    target = pc + XLEN'(ILEN_BYTES);
      PC_BRANCH: target = pc + imm;
      PC_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
      PC_TRAP:   target = trap_vec;
      default:   target = pc + XLEN'(ILEN_BYTES);
    endcase
  end

  // The trap vector is trusted; only computed targets are checked.
  assign misaligned = (src != PC_TRAP) && (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register, fetch handshake FSM, misalignment capture and fetch counter.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [1:0]       pc_src,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_plus_4,
  output logic             misalign_err,
  output logic [XLEN-1:0]  bad_addr,
  output logic [CNT_W-1:0] fetch_count
);

  state_e          state;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            redirect;
  logic            trap_redirect;
  logic            handshake;

  pc_target_calc #(
    .XLEN(XLEN)
  ) u_target_calc (
    .pc        (pc_out),
    .pc_src    (pc_src),
    .imm       (imm),
    .rs1_val   (rs1_val),
    .trap_vec  (trap_vec),
    .target    (target),
    .misaligned(misaligned)
  );

  assign pc_plus_4     = pc_out + XLEN'(ILEN_BYTES);
  assign redirect      = redirect_valid && (pc_src_e'(pc_src) != PC_SEQ);
  assign trap_redirect = redirect_valid && (pc_src_e'(pc_src) == PC_TRAP);
  assign handshake     = fetch_valid && fetch_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= BOOT;
      pc_out       <= RESET_VECTOR;
      fetch_valid  <= 1'b0;
      misalign_err <= 1'b0;
      bad_addr     <= '0;
      fetch_count  <= '0;
    end else begin
      // A redirect still counts the handshake made in the same cycle.
      if (handshake) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
      unique case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (redirect) begin
            if (misaligned) begin
              state        <= HALT;
              fetch_valid  <= 1'b0;
              misalign_err <= 1'b1;
              bad_addr     <= target;
            end else begin
              pc_out <= target;
            end
          end else if (stall) begin
            pc_out <= pc_out;
          end else if (handshake) begin
            pc_out <= pc_plus_4;
          end
        end
        HALT: begin
          if (trap_redirect) begin
            state        <= RUN;
            fetch_valid  <= 1'b1;
            misalign_err <= 1'b0;
            pc_out       <= trap_vec;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot, handshake, redirects, halt/trap, wrap and async reset.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] trap_vec;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4;
  logic        misalign_err;
  logic [31:0] bad_addr;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0000_1000),
    .CNT_W       (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .pc_src        (pc_src),
    .imm           (imm),
    .rs1_val       (rs1_val),
    .trap_vec      (trap_vec),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .pc_out        (pc_out),
    .pc_plus_4     (pc_plus_4),
    .misalign_err  (misalign_err),
    .bad_addr      (bad_addr),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect_valid = 1'b0; pc_src = 2'b00;
    imm = '0; rs1_val = '0; trap_vec = '0; fetch_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    step(); step();
    checks++; if (pc_out !== 32'h1000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h1000); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
    checks++; if (misalign_err !== 1'b0 || bad_addr !== 32'h0) begin errors++; $display("FAIL reset_err got %b/%h exp 0/0", misalign_err, bad_addr); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
    checks++; if (pc_plus_4 !== 32'h1004) begin errors++; $display("FAIL reset_pc4 got %h exp %h", pc_plus_4, 32'h1004); end
    reset_n = 1'b1;
    fetch_ready = 1'b1;
    step();
    // BOOT bubble: one cycle with no request and no PC change.
    checks++; if (fetch_valid !== 1'b1 || pc_out !== 32'h1000 || fetch_count !== 32'd0) begin errors++; $display("FAIL boot_run got v=%b pc=%h cnt=%0d exp v=1 pc=1000 cnt=0", fetch_valid, pc_out, fetch_count); end
    fetch_ready = 1'b0;
  endtask

  task automatic test_handshake();
    fetch_ready = 1'b1; step();
    checks++; if (pc_out !== 32'h1004) begin errors++; $display("FAIL hs_pc0 got %h exp %h", pc_out, 32'h1004); end
    fetch_ready = 1'b0; step();
    checks++; if (pc_out !== 32'h1004 || fetch_valid !== 1'b1) begin errors++; $display("FAIL hs_hold got pc=%h v=%b exp 1004/1", pc_out, fetch_valid); end
    fetch_ready = 1'b1; step();
    checks++; if (pc_out !== 32'h1008) begin errors++; $display("FAIL hs_pc2 got %h exp %h", pc_out, 32'h1008); end
    checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL hs_count got %0d exp 2", fetch_count); end
    step(); step();
    checks++; if (pc_out !== 32'h1010 || fetch_count !== 32'd4) begin errors++; $display("FAIL hs_run got pc=%h cnt=%0d exp 1010/4", pc_out, fetch_count); end
    fetch_ready = 1'b0;
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirect_valid = 1'b1; pc_src = 2'b01; imm = 32'hFFFF_FFF8;
    step();
    checks++; if (pc_out !== 32'h1008) begin errors++; $display("FAIL br_stall got %h exp %h", pc_out, 32'h1008); end
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    step();
    checks++; if (pc_out !== 32'h1008 || fetch_count !== 32'd5) begin errors++; $display("FAIL stall_hold got pc=%h cnt=%0d exp 1008/5", pc_out, fetch_count); end
    stall = 1'b0; redirect_valid = 1'b1; pc_src = 2'b01; imm = 32'h10;
    step();
    checks++; if (pc_out !== 32'h1018 || fetch_count !== 32'd6) begin errors++; $display("FAIL br_flush got pc=%h cnt=%0d exp 1018/6", pc_out, fetch_count); end
    fetch_ready = 1'b0; pc_src = 2'b00; imm = 32'h40;
    step();
    checks++; if (pc_out !== 32'h1018) begin errors++; $display("FAIL seq_redirect got %h exp %h", pc_out, 32'h1018); end
    pc_src = 2'b10; rs1_val = 32'h3001; imm = 32'h3;
    step();
    checks++; if (pc_out !== 32'h3004 || fetch_valid !== 1'b1) begin errors++; $display("FAIL jalr_ok got pc=%h v=%b exp 3004/1", pc_out, fetch_valid); end
    pc_src = 2'b01; imm = 32'h8;
    step();
    checks++; if (pc_out !== 32'h300C) begin errors++; $display("FAIL b2b_branch got %h exp %h", pc_out, 32'h300C); end
    idle_inputs();
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; pc_src = 2'b10; rs1_val = 32'h2001; imm = 32'h2;
    step();
    checks++; if (misalign_err !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_flags got err=%b v=%b exp 1/0", misalign_err, fetch_valid); end
    checks++; if (bad_addr !== 32'h2002 || pc_out !== 32'h300C) begin errors++; $display("FAIL halt_addr got bad=%h pc=%h exp 2002/300c", bad_addr, pc_out); end
    pc_src = 2'b01; imm = 32'h4; fetch_ready = 1'b1;
    step();
    checks++; if (pc_out !== 32'h300C || misalign_err !== 1'b1 || fetch_count !== 32'd6) begin errors++; $display("FAIL halt_ignore got pc=%h err=%b cnt=%0d exp 300c/1/6", pc_out, misalign_err, fetch_count); end
    fetch_ready = 1'b0; pc_src = 2'b11; trap_vec = 32'h100;
    step();
    checks++; if (pc_out !== 32'h100 || fetch_valid !== 1'b1 || misalign_err !== 1'b0) begin errors++; $display("FAIL trap_exit got pc=%h v=%b err=%b exp 100/1/0", pc_out, fetch_valid, misalign_err); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; pc_src = 2'b11; trap_vec = 32'hFFFF_FFFC;
    step();
    checks++; if (pc_out !== 32'hFFFF_FFFC || pc_plus_4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got pc=%h pc4=%h exp fffffffc/0", pc_out, pc_plus_4); end
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    step();
    checks++; if (pc_out !== 32'h0 || fetch_count !== 32'd7) begin errors++; $display("FAIL wrap_pc got pc=%h cnt=%0d exp 0/7", pc_out, fetch_count); end
  endtask

  task automatic test_async_reset();
    step();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pc_out !== 32'h1000 || fetch_valid !== 1'b0 || fetch_count !== 32'd0) begin errors++; $display("FAIL arst_now got pc=%h v=%b cnt=%0d exp 1000/0/0", pc_out, fetch_valid, fetch_count); end
    checks++; if (bad_addr !== 32'h0 || misalign_err !== 1'b0) begin errors++; $display("FAIL arst_err got bad=%h err=%b exp 0/0", bad_addr, misalign_err); end
    step();
    checks++; if (pc_out !== 32'h1000 || fetch_count !== 32'd0) begin errors++; $display("FAIL arst_hold got pc=%h cnt=%0d exp 1000/0", pc_out, fetch_count); end
    reset_n = 1'b1;
    step();
    checks++; if (fetch_valid !== 1'b1 || pc_out !== 32'h1000) begin errors++; $display("FAIL arst_boot got v=%b pc=%h exp 1/1000", fetch_valid, pc_out); end
    step();
    checks++; if (pc_out !== 32'h1004 || fetch_count !== 32'd1) begin errors++; $display("FAIL arst_run got pc=%h cnt=%0d exp 1004/1", pc_out, fetch_count); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_redirect();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
